// File: rtl/mcu_tx_queue_pkg.sv
// mcu_tx_pkg: shared types and constants for the MCU transmit queue.
//   tx_state_e        transmit FSM states (header states always present)
//   HDR_BYTE_DEFAULT  default frame header byte
//   clog2p1()         width of an occupancy count 0..DEPTH
package mcu_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_DRAIN,
    ST_HDR_ISSUE,
    ST_HDR_HOLD,
    ST_HDR_DRAIN
  } tx_state_e;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mcu_tx_queue_if.sv
// mcu_tx_queue_if: byte path between the VIC-side synchroniser, the queue and
// avr_interface.
//   in_data/in_strobe   synchronised byte and its new-data level
//   tx_busy/tx_block    avr_interface transmitter busy / MCU not ready
//   out_data/out_valid  byte and one-cycle send pulse to avr_interface
//   master: drives the inputs of the queue; slave: the queue itself.
interface mcu_tx_queue_if;
  logic [7:0] in_data;
  logic       in_strobe;
  logic       tx_busy;
  logic       tx_block;
  logic [7:0] out_data;
  logic       out_valid;

  modport master (
    output in_data, in_strobe, tx_busy, tx_block,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_strobe, tx_busy, tx_block,
    output out_data, out_valid
  );
endinterface

// File: rtl/mcu_tx_queue_fifo.sv
// mcu_tx_fifo: synchronous byte FIFO, DEPTH a power of 2.
//   push/push_data  write request; accepted when not full, or full with pop
//   pop             read request; ignored when empty
//   head            entry at the read pointer (valid when !empty)
//   full/empty/level occupancy, level is registered
module mcu_tx_fifo
  import mcu_tx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = clog2p1(DEPTH)
) (
  input  logic          sys_clock,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // storage is not reset; the pointers define what is valid
  always_ff @(posedge sys_clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mcu_tx_queue.sv
// mcu_tx_queue: buffers VIC config/status bytes for serial send to the MCU so
// back-to-back bytes survive a busy UART or a not-ready MCU.
//   sys_clock, rst_n  clock, async active-low reset
//   bus (slave)       in_data/in_strobe in, tx_busy/tx_block in,
//                     out_data/out_valid to avr_interface
//   clr_overflow      pulse clearing the sticky overflow flag
//   overflow          sticky: a byte was dropped on a full FIFO
//   level             FIFO occupancy
// Build option: MCU_TX_FRAME_EN sends every entry as HDR_BYTE then payload.
module mcu_tx_queue
  import mcu_tx_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic                      sys_clock,
  input  logic                      rst_n,
  mcu_tx_queue_if.slave             bus,
  input  logic                      clr_overflow,
  output logic                      overflow,
  output logic [clog2p1(DEPTH)-1:0] level
);
  localparam int STAGES = 1;

  logic              strobe_q, rise;
  logic [STAGES:0]   vld_pipe;
  logic [7:0]        cap_data;
  logic              push, pop, full, empty, drop;
  logic [7:0]        head;
  tx_state_e         state_q, state_d;

  // ---- capture: one entry per rising edge of the strobe level ----
  // vld_pipe[0]: rise seen; data is taken one cycle later once settled,
  // vld_pipe[1]: push of the captured byte.
  assign rise = bus.in_strobe & ~strobe_q;
  assign push = vld_pipe[STAGES];

  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
      vld_pipe <= '0;
      cap_data <= '0;
    end else begin
      strobe_q <= bus.in_strobe;
      vld_pipe <= {vld_pipe[STAGES-1:0], rise};
      if (vld_pipe[0]) cap_data <= bus.in_data;
    end
  end

  mcu_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sys_clock (sys_clock),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cap_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // ---- sticky overflow, set has priority over clear ----
  assign drop = push & full & ~pop;

  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // ---- send FSM ----
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // HOLD ignores tx_busy because avr_interface raises it a cycle late.
  // tx_block only gates leaving IDLE, so a started byte/frame always finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (!empty && !bus.tx_busy && !bus.tx_block)
`ifdef MCU_TX_FRAME_EN
          state_d = ST_HDR_ISSUE;
`else
          state_d = ST_ISSUE;
`endif
      ST_HDR_ISSUE: state_d = ST_HDR_HOLD;
      ST_HDR_HOLD:  state_d = ST_HDR_DRAIN;
      ST_HDR_DRAIN: if (!bus.tx_busy) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_HOLD;
      ST_HOLD:      state_d = ST_DRAIN;
      ST_DRAIN:     if (!bus.tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // the entry leaves only with its payload byte
  assign pop = (state_q == ST_ISSUE);

  // outputs registered from the next state so they line up with the ISSUE
  // states; out_data keeps its last value otherwise
  always_ff @(posedge sys_clock or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= (state_d == ST_ISSUE) || (state_d == ST_HDR_ISSUE);
      if (state_d == ST_ISSUE)          bus.out_data <= head;
      else if (state_d == ST_HDR_ISSUE) bus.out_data <= HDR_BYTE;
    end
  end

endmodule

// File: tb/tb_mcu_tx_queue.sv
module tb_mcu_tx_queue;
  import mcu_tx_pkg::*;

  localparam int DEPTH = 8;
  localparam int LW    = clog2p1(DEPTH);
`ifdef MCU_TX_FRAME_EN
  localparam bit FRAME = 1'b1;
`else
  localparam bit FRAME = 1'b0;
`endif

  logic          sys_clock;
  logic          rst_n;
  logic          clr_overflow;
  logic          overflow;
  logic [LW-1:0] level;

  mcu_tx_queue_if bus ();

  mcu_tx_queue #(.DEPTH(DEPTH), .HDR_BYTE(8'hA5)) dut (
    .sys_clock    (sys_clock),
    .rst_n        (rst_n),
    .bus          (bus),
    .clr_overflow (clr_overflow),
    .overflow     (overflow),
    .level        (level)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // ---- avr_interface stand-in and pulse monitor ----
  // tx_busy rises one cycle after each out_valid and stays up busy_len cycles.
  int          busy_len  = 0;
  int          busy_viol = 0;
  int          cyc       = 0;
  logic [7:0]  raw_q[$];     // every pulse
  logic [7:0]  pq[$];        // payload pulses
  int          pc[$];        // cycle stamp of each payload pulse

  initial begin
    int  busy_cnt;
    bit  lag, hdr_next;
    busy_cnt = 0; lag = 0; hdr_next = 1;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge sys_clock); #1;
      cyc++;
      if (!rst_n) begin
        busy_cnt = 0; lag = 0; hdr_next = 1;
        bus.tx_busy = 1'b0;
      end else begin
        if (bus.out_valid === 1'b1) begin
          if (bus.tx_busy) busy_viol++;
          raw_q.push_back(bus.out_data);
          if (FRAME && hdr_next) hdr_next = 0;
          else begin
            pq.push_back(bus.out_data);
            pc.push_back(cyc);
            hdr_next = 1;
          end
        end
        if (lag) begin
          if (busy_len > 0) begin bus.tx_busy = 1'b1; busy_cnt = busy_len; end
          lag = 0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) bus.tx_busy = 1'b0;
        end
        if (bus.out_valid === 1'b1) lag = 1;
      end
    end
  end

  // ---- stimulus helpers (drive on negedge) ----
  // One strobe pulse; clr_overflow is optionally held over the push cycle.
  task automatic push_byte(input logic [7:0] d, input bit clr_at_push);
    @(negedge sys_clock); bus.in_data = d; bus.in_strobe = 1'b1;
    @(negedge sys_clock); bus.in_strobe = 1'b0;
    @(negedge sys_clock); clr_overflow = clr_at_push;
    @(negedge sys_clock); clr_overflow = 1'b0;
    @(negedge sys_clock);
  endtask

  task automatic pulse_clr();
    @(negedge sys_clock); clr_overflow = 1'b1;
    @(negedge sys_clock); clr_overflow = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pq.size() < n && k < budget) begin @(negedge sys_clock); k++; end
    chk(name, pq.size(), n);
  endtask

  typedef struct {
    bit         do_push;
    logic [7:0] data;
    bit         clr;
    logic [7:0] exp_level;
    bit         exp_ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // overflow table: tx_block held, so nothing drains
    for (int i = 0; i < 9; i++)
      tbl[i] = '{1'b1, 8'(i + 1), 1'b0, (i < 8) ? 8'(i + 1) : 8'd8, (i == 8)};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 8'd8, 1'b0};  // clear
    tbl[10] = '{1'b1, 8'hAA, 1'b1, 8'd8, 1'b1};  // drop + clear together: set wins
    tbl[11] = '{1'b0, 8'h00, 1'b1, 8'd8, 1'b0};  // clear again

    rst_n = 1'b0; clr_overflow = 1'b0;
    bus.in_data = 8'h00; bus.in_strobe = 1'b0; bus.tx_block = 1'b0;
    repeat (3) @(negedge sys_clock);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data",  bus.out_data, 0);
    chk("reset overflow",  overflow, 0);
    chk("reset level",     level, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clock);

    // ---- 1: single byte, strobe 2 cycles, 2-cycle capture latency ----
    busy_len = 3; pq.delete(); raw_q.delete();
    bus.in_data = 8'h3C; bus.in_strobe = 1'b1;
    @(negedge sys_clock); chk("t1 level after rise edge", level, 0);
    @(negedge sys_clock); chk("t1 level +1 edge", level, 0);
    bus.in_strobe = 1'b0;
    @(negedge sys_clock); chk("t1 level +2 edges", level, 1);
    wait_pulses(1, 50, "t1 pulse seen");
    repeat (20) @(negedge sys_clock);
    chk("t1 pulse count", pq.size(), 1);
    if (pq.size() > 0) chk("t1 data", pq[0], 8'h3C);
    chk("t1 overflow", overflow, 0);

    // ---- 2: long strobe -> single push; new rise -> second push ----
    pq.delete(); bus.tx_block = 1'b1;
    @(negedge sys_clock); bus.in_data = 8'h11; bus.in_strobe = 1'b1;
    repeat (10) @(negedge sys_clock);
    bus.in_strobe = 1'b0;
    repeat (3) @(negedge sys_clock);
    chk("t2 level after long strobe", level, 1);
    push_byte(8'h22, 1'b0);
    chk("t2 level after second rise", level, 2);
    bus.tx_block = 1'b0;
    wait_pulses(2, 100, "t2 pulses");
    if (pq.size() >= 2) begin
      chk("t2 data0", pq[0], 8'h11);
      chk("t2 data1", pq[1], 8'h22);
    end

    // ---- 3: long busy, spacing and order ----
    busy_len = 200; pq.delete(); pc.delete(); busy_viol = 0;
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    push_byte(8'h03, 1'b0);
    wait_pulses(3, 1500, "t3 pulses");
    if (pq.size() >= 3) begin
      chk("t3 data0", pq[0], 8'h01);
      chk("t3 data1", pq[1], 8'h02);
      chk("t3 data2", pq[2], 8'h03);
      chk("t3 spacing 0-1 >=200", (pc[1] - pc[0]) >= 200, 1);
      chk("t3 spacing 1-2 >=200", (pc[2] - pc[1]) >= 200, 1);
    end
    chk("t3 no pulse while busy", busy_viol, 0);
    repeat (220) @(negedge sys_clock);

    // ---- 4: table-driven fill / overflow / clear, then drain ----
    busy_len = 2; pq.delete(); bus.tx_block = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_push) push_byte(tbl[i].data, tbl[i].clr);
      else if (tbl[i].clr) pulse_clr();
      chk($sformatf("t4[%0d] level", i), level, tbl[i].exp_level);
      chk($sformatf("t4[%0d] overflow", i), overflow, tbl[i].exp_ovf);
    end
    bus.tx_block = 1'b0;
    wait_pulses(8, 300, "t4 drain pulses");
    repeat (20) @(negedge sys_clock);
    chk("t4 pulse count", pq.size(), 8);
    for (int i = 0; i < 8 && i < pq.size(); i++)
      chk($sformatf("t4 drain[%0d]", i), pq[i], 8'(i + 1));
    chk("t4 level empty", level, 0);

    // ---- 5: reset during DRAIN with 3 queued ----
    busy_len = 50; pq.delete(); bus.tx_block = 1'b1;
    for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i), 1'b0);
    bus.tx_block = 1'b0;
    wait_pulses(1, 50, "t5 first pulse");
    repeat (5) @(negedge sys_clock);
    chk("t5 level before reset", level, 3);
    chk("t5 out_data before reset", bus.out_data, 8'h41);
    rst_n = 1'b0;
    #1;
    chk("t5 reset out_data", bus.out_data, 0);
    chk("t5 reset out_valid", bus.out_valid, 0);
    chk("t5 reset level", level, 0);
    chk("t5 reset overflow", overflow, 0);
    repeat (2) @(negedge sys_clock);
    rst_n = 1'b1;
    repeat (30) @(negedge sys_clock);
    chk("t5 no pulse after reset", pq.size(), 1);

`ifdef MCU_TX_FRAME_EN
    // ---- 6: header + payload; tx_block mid-frame does not split it ----
    begin
      int k;
      busy_len = 3; raw_q.delete(); pq.delete();
      @(negedge sys_clock); bus.in_data = 8'h7E; bus.in_strobe = 1'b1;
      @(negedge sys_clock); bus.in_strobe = 1'b0;
      k = 0;
      while (raw_q.size() < 1 && k < 50) begin @(negedge sys_clock); k++; end
      bus.tx_block = 1'b1;
      k = 0;
      while (raw_q.size() < 2 && k < 50) begin @(negedge sys_clock); k++; end
      chk("t6 frame pulses", raw_q.size(), 2);
      if (raw_q.size() >= 2) begin
        chk("t6 header", raw_q[0], 8'hA5);
        chk("t6 payload", raw_q[1], 8'h7E);
      end
      bus.tx_block = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
